// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: walks cx/cy over the full frame and
// presents one registered beat at a time under a valid/ready handshake.
// Optional build macro VTG_LINE_IRQ_EN adds a per-frame line-compare pulse.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          ready,
    output logic          valid,
    output logic          data_enable,
    output logic          hsync,
    output logic          vsync,
    output logic          sof,
    output logic          eol,
    output logic [CW-1:0] cx,
    output logic [CW-1:0] cy,
    output logic [CW-1:0] screen_width,
    output logic [CW-1:0] frame_width
`ifdef VTG_LINE_IRQ_EN
    ,
    input  logic [CW-1:0] line_cmp,
    output logic          line_irq
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          run_next;
    logic [CW-1:0] cx_next;
    logic [CW-1:0] cy_next;
    logic          de_next;
    logic          hs_next;
    logic          vs_next;
    logic          sof_next;
    logic          eol_next;

    // Handshake: a beat transfers on a rising edge where valid && ready. While
    // valid is high and ready is low, every beat output holds; valid only
    // falls in the cycle after an accepted beat.
    assign valid        = (state == RUN);
    assign accept       = valid && ready;
    assign screen_width = H_ACT_C;
    assign frame_width  = CW'(H_TOTAL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable) state_next = RUN;
            RUN:  if (ready && !enable) state_next = IDLE;
        endcase
    end

    // Position and flags for the beat presented next cycle; flags are forced
    // inactive whenever that cycle will not carry a valid beat.
    always_comb begin
        cx_next = cx;
        cy_next = cy;
        if (accept) begin
            if (cx == H_LAST) begin
                cx_next = '0;
                cy_next = (cy == V_LAST) ? '0 : cy + CW'(1);
            end else begin
                cx_next = cx + CW'(1);
            end
        end
        run_next = (state_next == RUN);
        de_next  = run_next && (cx_next < H_ACT_C) && (cy_next < V_ACT_C);
        hs_next  = (run_next && (cx_next >= HS_START) && (cx_next < HS_END)) ? HS_POL : ~HS_POL;
        vs_next  = (run_next && (cy_next >= VS_START) && (cy_next < VS_END)) ? VS_POL : ~VS_POL;
        sof_next = run_next && (cx_next == '0) && (cy_next == '0);
        eol_next = run_next && (cx_next == H_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx          <= '0;
            cy          <= '0;
            data_enable <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            sof         <= 1'b0;
            eol         <= 1'b0;
        end else begin
            cx          <= cx_next;
            cy          <= cy_next;
            data_enable <= de_next;
            hsync       <= hs_next;
            vsync       <= vs_next;
            sof         <= sof_next;
            eol         <= eol_next;
        end
    end

`ifdef VTG_LINE_IRQ_EN
    // cy never reaches V_TOTAL, so out-of-range compare values cannot fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_irq <= 1'b0;
        end else begin
            line_irq <= accept && (cx == '0) && (cy == line_cmp);
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on an 8x6 raster (4x3 active area).
// Line-compare checks are compiled in only when VTG_LINE_IRQ_EN is defined.
module tb_video_timing_gen;

    localparam int CW = 16;
    localparam int VW = 6 + 2 * CW;
    localparam int HT = 8;
    localparam int VT = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          ready = 1'b0;
    logic          valid;
    logic          data_enable;
    logic          hsync;
    logic          vsync;
    logic          sof;
    logic          eol;
    logic [CW-1:0] cx;
    logic [CW-1:0] cy;
    logic [CW-1:0] screen_width;
    logic [CW-1:0] frame_width;
`ifdef VTG_LINE_IRQ_EN
    logic [CW-1:0] line_cmp = CW'(9);
    logic          line_irq;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the beat expected on the outputs right now.
    bit   m_valid = 1'b0;
    int   m_x = 0;
    int   m_y = 0;
    logic exp_irq = 1'b0;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .ready(ready),
        .valid(valid),
        .data_enable(data_enable),
        .hsync(hsync),
        .vsync(vsync),
        .sof(sof),
        .eol(eol),
        .cx(cx),
        .cy(cy),
        .screen_width(screen_width),
        .frame_width(frame_width)
`ifdef VTG_LINE_IRQ_EN
        ,
        .line_cmp(line_cmp),
        .line_irq(line_irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] obs_vec();
        return {valid, data_enable, hsync, vsync, sof, eol, cx, cy};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic de, hs, vs, sf, el;
        de = (m_x < 4) && (m_y < 3);
        hs = (m_x >= 5) && (m_x <= 6);
        vs = (m_y == 4);
        sf = (m_x == 0) && (m_y == 0);
        el = (m_x == HT - 1);
        if (m_valid)
            return {1'b1, de, hs, vs, sf, el, CW'(m_x), CW'(m_y)};
        return {6'b000000, CW'(m_x), CW'(m_y)};
    endfunction

    // Flags are only meaningful on valid beats; position is always checked.
    function automatic logic [VW-1:0] cmp_mask();
        if (m_valid) return '1;
        return {1'b1, 5'b00000, {CW{1'b1}}, {CW{1'b1}}};
    endfunction

    // One clock: predict from the inputs in force, step, then settle.
    task automatic tick();
        bit   nv;
        int   nx, ny;
        logic ni;
        nv = m_valid; nx = m_x; ny = m_y; ni = 1'b0;
        if (!m_valid) begin
            nv = enable;
        end else if (ready) begin
`ifdef VTG_LINE_IRQ_EN
            ni = (m_x == 0) && (m_y == int'(line_cmp));
`endif
            if (m_x == HT - 1) begin
                nx = 0;
                ny = (m_y == VT - 1) ? 0 : m_y + 1;
            end else begin
                nx = m_x + 1;
            end
            nv = enable;
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_x = nx; m_y = ny; exp_irq = ni;
    endtask

    task automatic run_to(input int x, input int y);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (m_valid && m_x == x && m_y == y) begin
                hit = 1'b1;
                break;
            end
            tick();
            n_vec++;
            if ((obs_vec() & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
                n_err++;
                $display("FAIL run_to: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL run_to_reach: got x=%0d y=%0d expected x=%0d y=%0d", m_x, m_y, x, y);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs_vec() !== {6'b000000, 16'd0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), {6'b000000, 16'd0, 16'd0});
        end
        n_vec++;
        if (screen_width !== 16'd4 || frame_width !== 16'd8) begin
            n_err++;
            $display("FAIL widths: got %0d/%0d expected 4/8", screen_width, frame_width);
        end
        reset = 1'b1; enable = 1'b1; ready = 1'b1;
        m_valid = 1'b0; m_x = 0; m_y = 0;
    endtask

    task automatic test_raster();
        for (int i = 0; i < 49; i++) begin
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec() || cx !== CW'(i % HT) || cy !== CW'((i / HT) % VT)) begin
                n_err++;
                $display("FAIL raster beat %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (sof !== 1'b1 || valid !== 1'b1 || data_enable !== 1'b1) begin
            n_err++;
            $display("FAIL raster_wrap_sof: got sof=%b valid=%b de=%b expected 1/1/1", sof, valid, data_enable);
        end
    endtask

    task automatic test_stall();
        run_to(2, 1);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            enable = ((k % 2) == 0) ? 1'b0 : 1'b1;
            tick();
            n_vec++;
            if (obs_vec() !== {6'b110000, 16'd2, 16'd1}) begin
                n_err++;
                $display("FAIL stall_hold %0d: got %h expected %h", k, obs_vec(), {6'b110000, 16'd2, 16'd1});
            end
        end
        enable = 1'b1; ready = 1'b1;
        tick();
        n_vec++;
        if (obs_vec() !== {6'b110000, 16'd3, 16'd1}) begin
            n_err++;
            $display("FAIL stall_release: got %h expected %h", obs_vec(), {6'b110000, 16'd3, 16'd1});
        end
    endtask

    task automatic test_disable();
        run_to(6, 1);
        enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if (valid !== 1'b0 || cx !== 16'd7 || cy !== 16'd1) begin
                n_err++;
                $display("FAIL disable_idle %0d: got v=%b cx=%0d cy=%0d expected v=0 cx=7 cy=1", k, valid, cx, cy);
            end
        end
        enable = 1'b1;
        tick();
        n_vec++;
        if (obs_vec() !== {6'b100001, 16'd7, 16'd1}) begin
            n_err++;
            $display("FAIL resume_beat: got %h expected %h", obs_vec(), {6'b100001, 16'd7, 16'd1});
        end
        tick();
        n_vec++;
        if (obs_vec() !== {6'b110000, 16'd0, 16'd2}) begin
            n_err++;
            $display("FAIL resume_next: got %h expected %h", obs_vec(), {6'b110000, 16'd0, 16'd2});
        end
    endtask

    task automatic test_reset_mid();
        run_to(5, 2);
        n_vec++;
        if (hsync !== 1'b1) begin
            n_err++;
            $display("FAIL hsync_before_reset: got %b expected 1", hsync);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (obs_vec() !== {6'b000000, 16'd0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_async: got %h expected %h", obs_vec(), {6'b000000, 16'd0, 16'd0});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (obs_vec() !== {6'b000000, 16'd0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_hold: got %h expected %h", obs_vec(), {6'b000000, 16'd0, 16'd0});
        end
        reset = 1'b1; enable = 1'b1; ready = 1'b1;
        m_valid = 1'b0; m_x = 0; m_y = 0; exp_irq = 1'b0;
        tick();
        n_vec++;
        if (obs_vec() !== {6'b110010, 16'd0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_restart_sof: got %h expected %h", obs_vec(), {6'b110010, 16'd0, 16'd0});
        end
    endtask

`ifdef VTG_LINE_IRQ_EN
    task automatic test_line_irq();
        int pulses;
        line_cmp = CW'(4);
        pulses = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick();
            if (line_irq === 1'b1) pulses++;
            n_vec++;
            if (line_irq !== exp_irq) begin
                n_err++;
                $display("FAIL line_irq_timing %0d: got %b expected %b", i, line_irq, exp_irq);
            end
        end
        n_vec++;
        if (pulses != 2) begin
            n_err++;
            $display("FAIL line_irq_count: got %0d expected 2", pulses);
        end
        line_cmp = CW'(9);
        pulses = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick();
            if (line_irq !== 1'b0) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL line_irq_out_of_range: got %0d pulses expected 0", pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_raster();
        test_stall();
        test_disable();
        test_reset_mid();
`ifdef VTG_LINE_IRQ_EN
        test_line_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
